banked_latency_dmem: RTL and testbench

- Parametrised successor of the fixed 256-bit, 512-line external data memory that services L1 data-cache refills and write-backs.
- Adds configurable width, depth and separate read/write latencies.
- Adds a per-byte write mask and out-of-range error reporting.
- Sits between the L1 cache miss FSM and the system boundary; keeps the enable/write/ack request handshake.

---
 rtl/banked_latency_dmem_if.sv | 17 +
 rtl/banked_latency_dmem.sv | 131 +++++++++++++
 tb/tb_banked_latency_dmem.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/banked_latency_dmem_if.sv
// banked_latency_dmem_if: request/response bus between the cache miss FSM and the latency-modelled data memory.
interface banked_latency_dmem_if #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   addr_i;
    logic [DATA_WIDTH-1:0]   data_i;
    logic [DATA_WIDTH/8-1:0] be_i;
    logic                    enable_i;
    logic                    write_i;
    logic                    ack_o;
    logic [DATA_WIDTH-1:0]   data_o;
    logic                    busy_o;
    logic                    err_o;
    modport master (output addr_i, data_i, be_i, enable_i, write_i, input ack_o, data_o, busy_o, err_o);
    modport slave  (input addr_i, data_i, be_i, enable_i, write_i, output ack_o, data_o, busy_o, err_o);
endinterface

// File: rtl/banked_latency_dmem.sv
// banked_latency_dmem: line memory with separate read/write latency, byte-masked writes and range errors.
// Defining DMEM_STATS_EN adds wrapping read/write completion counters.
module banked_latency_dmem #(
    parameter int DATA_WIDTH  = 256,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH   = 512,
    parameter int READ_DELAY  = 10,
    parameter int WRITE_DELAY = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    banked_latency_dmem_if.slave bus
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0] rd_count_o,
    output logic [31:0] wr_count_o
`endif
);
    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFF  = $clog2(NB);
    localparam int IW   = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
    localparam int MAXD = READ_DELAY > WRITE_DELAY ? READ_DELAY : WRITE_DELAY;
    localparam int CW   = $clog2(MAXD + 1);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d, load;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, req_addr, idx;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, data_q, data_d, req_data;
    logic [NB-1:0]         be_q, be_d, req_be;
    logic                  write_q, write_d, err_q, err_d;
    logic                  idle, go_ack, req_write, in_range, mem_we;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    assign idle = state_q == IDLE;
    // A delay of 1 jumps IDLE->ACK on the accepting edge, so the live inputs stand in for the latched copies
    assign req_addr  = idle ? bus.addr_i  : addr_q;
    assign req_data  = idle ? bus.data_i  : wdata_q;
    assign req_be    = idle ? bus.be_i    : be_q;
    assign req_write = idle ? bus.write_i : write_q;
    assign idx       = req_addr >> OFF;
    assign in_range  = idx < ADDR_WIDTH'(MEM_DEPTH);
    assign load      = req_write ? CW'(WRITE_DELAY - 1) : CW'(READ_DELAY - 1);
    assign mem_we    = go_ack && req_write && in_range && rst_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        write_d = write_q;
        go_ack  = 1'b0;
        case (state_q)
            IDLE: if (bus.enable_i) begin
                addr_d  = bus.addr_i;
                wdata_d = bus.data_i;
                be_d    = bus.be_i;
                write_d = bus.write_i;
                cnt_d   = load;
                go_ack  = load == '0;
                state_d = go_ack ? ACK : WAIT;
            end
            WAIT: begin
                cnt_d   = cnt_q - CW'(1);
                go_ack  = cnt_q == CW'(1);
                state_d = go_ack ? ACK : WAIT;
            end
            default: state_d = IDLE;
        endcase
        data_d = (go_ack && !req_write) ? (in_range ? mem[idx[IW-1:0]] : '0) : data_q;
        err_d  = go_ack && !in_range;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            write_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            write_q <= write_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Array contents survive reset
    always_ff @(posedge clk_i) begin
        if (mem_we)
            for (int k = 0; k < NB; k++)
                if (req_be[k]) mem[idx[IW-1:0]][8*k +: 8] <= req_data[8*k +: 8];
    end

    assign bus.ack_o  = state_q == ACK;
    assign bus.err_o  = err_q;
    assign bus.busy_o = !idle;
    assign bus.data_o = data_q;

`ifdef DMEM_STATS_EN
    logic [31:0] rd_count_q, rd_count_d, wr_count_q, wr_count_d;

    always_comb begin
        rd_count_d = rd_count_q + 32'(state_q == ACK && !write_q);
        wr_count_d = wr_count_q + 32'(state_q == ACK && write_q);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count_o = rd_count_q;
    assign wr_count_o = wr_count_q;
`endif
endmodule

// File: tb/tb_banked_latency_dmem.sv
// tb_banked_latency_dmem: table vectors, hand sequences and randomized traffic against a line-array model.
// Instance 0 uses defaults; instance 1 is a narrow 16-line memory with read delay 1 and write delay 3.
module tb_banked_latency_dmem;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    banked_latency_dmem_if #(.DATA_WIDTH(256), .ADDR_WIDTH(32)) bus0();
    banked_latency_dmem_if #(.DATA_WIDTH(32),  .ADDR_WIDTH(16)) bus1();

`ifdef DMEM_STATS_EN
    logic [31:0] rc0, wc0, rc1, wc1;
`endif

    banked_latency_dmem dut0 (
        .clk_i(clk), .rst_i(rst_n), .bus(bus0.slave)
`ifdef DMEM_STATS_EN
        , .rd_count_o(rc0), .wr_count_o(wc0)
`endif
    );

    banked_latency_dmem #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_DEPTH(16),
                          .READ_DELAY(1), .WRITE_DELAY(3)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .bus(bus1.slave)
`ifdef DMEM_STATS_EN
        , .rd_count_o(rc1), .wr_count_o(wc1)
`endif
    );

    int nvec = 0;
    int nerr = 0;

    logic [255:0] m0 [512];
    logic [31:0]  m1 [16];
    logic [255:0] last [2];
    int erc [2];
    int ewc [2];

    typedef struct {
        bit           s;
        bit           w;
        logic [31:0]  a;
        logic [255:0] d;
        logic [31:0]  be;
        int           lat;
        bit           er;
        bit           crd;
        logic [255:0] rd;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic ack_of(input int s);
        return s == 0 ? bus0.ack_o : bus1.ack_o;
    endfunction
    function automatic logic busy_of(input int s);
        return s == 0 ? bus0.busy_o : bus1.busy_o;
    endfunction
    function automatic logic err_of(input int s);
        return s == 0 ? bus0.err_o : bus1.err_o;
    endfunction
    function automatic logic [255:0] dout_of(input int s);
        return s == 0 ? bus0.data_o : {224'b0, bus1.data_o};
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic drive(input int s, input logic en, input logic w, input logic [31:0] a,
                         input logic [255:0] d, input logic [31:0] be);
        if (s == 0) begin
            bus0.enable_i = en; bus0.write_i = w; bus0.addr_i = a; bus0.data_i = d; bus0.be_i = be;
        end else begin
            bus1.enable_i = en; bus1.write_i = w; bus1.addr_i = a[15:0]; bus1.data_i = d[31:0]; bus1.be_i = be[3:0];
        end
    endtask

    // Issues one request and returns cycles from acceptance to ack, busy cycles, read data and error flag
    task automatic req(input int s, input logic w, input logic [31:0] a, input logic [255:0] d,
                       input logic [31:0] be, output int lat, output int bn,
                       output logic [255:0] rd, output logic er);
        @(negedge clk);
        drive(s, 1'b1, w, a, d, be);
        lat = 0;
        bn  = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (busy_of(s)) bn++;
        end while (!ack_of(s) && lat < 100);
        rd = dout_of(s);
        er = err_of(s);
        drive(s, 1'b0, w, a, d, be);
        if (ack_of(s)) begin
            if (w) ewc[s]++; else erc[s]++;
        end
        @(posedge clk); #1;
        chk("ack_one_cycle", {255'b0, ack_of(s)}, 256'b0);
    endtask

    // Reference: a plain array of lines indexed by byte address / line size
    task automatic model_op(input int s, input logic w, input logic [31:0] a, input logic [255:0] d,
                            input logic [31:0] be, output logic er, output logic [255:0] rd);
        int nb  = s == 0 ? 32 : 4;
        int dep = s == 0 ? 512 : 16;
        int idx = int'(a / nb);
        er = idx >= dep;
        if (w && !er) begin
            for (int k = 0; k < nb; k++)
                if (be[k]) begin
                    if (s == 0) m0[idx][8*k +: 8] = d[8*k +: 8];
                    else        m1[idx][8*k +: 8] = d[8*k +: 8];
                end
        end
        if (!w) last[s] = er ? 256'b0 : (s == 0 ? m0[idx] : {224'b0, m1[idx]});
        rd = last[s];
    endtask

    task automatic run_check(input int s, input logic w, input logic [31:0] a, input logic [255:0] d,
                             input logic [31:0] be, input string nm);
        int lat, bn, elat;
        logic [255:0] rd, erd;
        logic er, eer;
        req(s, w, a, d, be, lat, bn, rd, er);
        model_op(s, w, a, d, be, eer, erd);
        elat = s == 0 ? 10 : (w ? 3 : 1);
        chk({nm, "_lat"},  256'(lat), 256'(elat));
        chk({nm, "_busy"}, 256'(bn),  256'(elat));
        chk({nm, "_err"},  {255'b0, er}, {255'b0, eer});
        chk({nm, "_data"}, rd, erd);
    endtask

    function automatic vec_t mk(bit s, bit w, logic [31:0] a, logic [255:0] d, logic [31:0] be,
                                int lat, bit er, bit crd, logic [255:0] rd);
        vec_t v;
        v.s = s; v.w = w; v.a = a; v.d = d; v.be = be; v.lat = lat; v.er = er; v.crd = crd; v.rd = rd;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, bn, acks, first, second, nxt;
        logic [255:0] rd, erd, all_aa, ones;
        logic er, eer;
        erc = '{0, 0};
        ewc = '{0, 0};
        last = '{256'b0, 256'b0};
        all_aa = {32{8'hAA}};
        ones = '1;
        drive(0, 1'b0, 1'b0, 32'h0, 256'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 256'h0, 32'h0);

        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("rst_ack",  {255'b0, ack_of(s)},  256'b0);
            chk("rst_err",  {255'b0, err_of(s)},  256'b0);
            chk("rst_busy", {255'b0, busy_of(s)}, 256'b0);
            chk("rst_data", dout_of(s), 256'b0);
        end
`ifdef DMEM_STATS_EN
        chk("rst_cnt", {128'b0, rc0, wc0, rc1, wc1}, 256'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 512; i++) run_check(0, 1'b1, 32'(i * 32), rnd256(), 32'hFFFF_FFFF, "init0");
        for (int i = 0; i < 16; i++)  run_check(1, 1'b1, 32'(i * 4), rnd256(), 32'hF, "init1");

        tbl[0]  = mk(0, 1, 32'h0,    256'h5,    32'hFFFF_FFFF, 10, 0, 0, 256'h0);
        tbl[1]  = mk(0, 0, 32'h0,    256'h0,    32'h0,         10, 0, 1, 256'h5);
        tbl[2]  = mk(0, 1, 32'h20,   256'h0,    32'hFFFF_FFFF, 10, 0, 0, 256'h0);
        tbl[3]  = mk(0, 1, 32'h20,   all_aa,    32'h0000_000F, 10, 0, 0, 256'h0);
        tbl[4]  = mk(0, 0, 32'h20,   256'h0,    32'h0,         10, 0, 1, 256'hAAAA_AAAA);
        tbl[5]  = mk(0, 0, 32'h4000, 256'h0,    32'h0,         10, 1, 1, 256'h0);
        tbl[6]  = mk(0, 1, 32'h4000, ones,      32'hFFFF_FFFF, 10, 1, 1, 256'h0);
        tbl[7]  = mk(0, 1, 32'h3FE5, {8{32'hDEAD_BEEF}}, 32'hFFFF_FFFF, 10, 0, 0, 256'h0);
        tbl[8]  = mk(0, 0, 32'h3FFF, 256'h0,    32'h0,         10, 0, 1, {8{32'hDEAD_BEEF}});
        tbl[9]  = mk(0, 1, 32'h20,   ones,      32'h0,         10, 0, 0, 256'h0);
        tbl[10] = mk(0, 0, 32'h3C,   256'h0,    32'h0,         10, 0, 1, 256'hAAAA_AAAA);
        tbl[11] = mk(1, 1, 32'h4,    256'h0,    32'hF,         3,  0, 0, 256'h0);
        tbl[12] = mk(1, 1, 32'h6,    256'h1234_5678, 32'h6,    3,  0, 0, 256'h0);
        tbl[13] = mk(1, 0, 32'h4,    256'h0,    32'h0,         1,  0, 1, 256'h0034_5600);
        tbl[14] = mk(1, 0, 32'h40,   256'h0,    32'h0,         1,  1, 1, 256'h0);
        tbl[15] = mk(1, 1, 32'h3C,   256'hCAFE_F00D, 32'hF,    3,  0, 0, 256'h0);
        tbl[16] = mk(1, 0, 32'h3F,   256'h0,    32'h0,         1,  0, 1, 256'hCAFE_F00D);

        for (int i = 0; i < 17; i++) begin
            req(tbl[i].s, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].be, lat, bn, rd, er);
            model_op(tbl[i].s, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].be, eer, erd);
            chk($sformatf("vec%0d_lat", i),  256'(lat), 256'(tbl[i].lat));
            chk($sformatf("vec%0d_busy", i), 256'(bn),  256'(tbl[i].lat));
            chk($sformatf("vec%0d_err", i),  {255'b0, er}, {255'b0, tbl[i].er});
            if (tbl[i].crd) chk($sformatf("vec%0d_data", i), rd, tbl[i].rd);
        end

        // Held enable: repeated reads of line 0 must be spaced by ACK plus the IDLE cycle
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'h0, 256'h0, 32'h0);
        acks = 0; first = -1; second = -1; nxt = -1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (first > 0 && c == first + 1) nxt = int'(bus0.ack_o);
            if (bus0.ack_o) begin
                acks++;
                if (first < 0) first = c; else if (second < 0) second = c;
            end
        end
        drive(0, 1'b0, 1'b0, 32'h0, 256'h0, 32'h0);
        chk("held_acks", 256'(acks), 256'd2);
        chk("held_first", 256'(first), 256'd10);
        chk("held_spacing", 256'(second - first), 256'd11);
        chk("held_no_double", 256'(nxt), 256'd0);
        for (int c = 0; c < 40 && bus0.busy_o; c++) begin
            @(posedge clk); #1;
            if (bus0.ack_o) acks++;
        end
        chk("held_drain", {255'b0, bus0.busy_o}, 256'b0);
        erc[0] += acks;
        last[0] = m0[0];
        chk("held_data", bus0.data_o, m0[0]);

        // Abort: reset two cycles into a write must leave line 2 untouched
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h40, ones, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {255'b0, bus0.busy_o}, 256'b0);
        chk("abort_ack",  {255'b0, bus0.ack_o},  256'b0);
        chk("abort_data", bus0.data_o, 256'b0);
        drive(0, 1'b0, 1'b0, 32'h0, 256'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last = '{256'b0, 256'b0};
        erc = '{0, 0};
        ewc = '{0, 0};
        acks = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (bus0.ack_o) acks++;
        end
        chk("abort_no_ack", 256'(acks), 256'd0);
        run_check(0, 1'b0, 32'h40, 256'h0, 32'h0, "abort_read");

        for (int i = 0; i < 300; i++) begin
            int s = int'($urandom_range(0, 1));
            int nb = s == 0 ? 32 : 4;
            int idx = int'($urandom_range(0, s == 0 ? 515 : 19));
            logic [31:0] a = 32'(idx * nb) + 32'($urandom_range(0, nb - 1));
            run_check(s, 1'($urandom_range(0, 1)), a, rnd256(), $urandom, "rand");
        end

        for (int i = 0; i < 512; i += 37) run_check(0, 1'b0, 32'(i * 32), 256'h0, 32'h0, "sweep");

`ifdef DMEM_STATS_EN
        @(posedge clk); #1;
        chk("cnt_rd0", {224'b0, rc0}, 256'(erc[0]));
        chk("cnt_wr0", {224'b0, wc0}, 256'(ewc[0]));
        chk("cnt_rd1", {224'b0, rc1}, 256'(erc[1]));
        chk("cnt_wr1", {224'b0, wc1}, 256'(ewc[1]));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
